ssd_scan_ctl: RTL and testbench

//  Parametrised, self-timed multiplexer for a common-anode seven-segment display (active-low anodes and segments).

---
 rtl/ssd_pkg.sv | 38 +++
 rtl/ssd_refresh_tick.sv | 22 ++
 rtl/ssd_scan_ctl.sv | 110 +++++++++++
 tb/tb_ssd_scan_ctl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: bit width, active-low digit codes and the blank value.
// Segment order is {dp,g,f,e,d,c,b,a}, and a 0 bit lights the segment.
package ssd_pkg;

  localparam int SSD_BIT_WIDTH = 8;

  localparam logic [SSD_BIT_WIDTH-1:0] SSD_BLANK = 8'hFF;
  localparam logic [SSD_BIT_WIDTH-1:0] SSD_0     = 8'hC0;
  localparam logic [SSD_BIT_WIDTH-1:0] SSD_1     = 8'hF9;
  localparam logic [SSD_BIT_WIDTH-1:0] SSD_2     = 8'hA4;
  localparam logic [SSD_BIT_WIDTH-1:0] SSD_3     = 8'hB0;
  localparam logic [SSD_BIT_WIDTH-1:0] SSD_4     = 8'h99;
  localparam logic [SSD_BIT_WIDTH-1:0] SSD_5     = 8'h92;
  localparam logic [SSD_BIT_WIDTH-1:0] SSD_6     = 8'h82;
  localparam logic [SSD_BIT_WIDTH-1:0] SSD_7     = 8'hF8;
  localparam logic [SSD_BIT_WIDTH-1:0] SSD_8     = 8'h80;
  localparam logic [SSD_BIT_WIDTH-1:0] SSD_9     = 8'h90;

  function automatic logic [SSD_BIT_WIDTH-1:0] ssd_digit(input logic [3:0] val);
    logic [SSD_BIT_WIDTH-1:0] code;
    code = SSD_BLANK;
    case (val)
      4'd0: code = SSD_0;
      4'd1: code = SSD_1;
      4'd2: code = SSD_2;
      4'd3: code = SSD_3;
      4'd4: code = SSD_4;
      4'd5: code = SSD_5;
      4'd6: code = SSD_6;
      4'd7: code = SSD_7;
      4'd8: code = SSD_8;
      4'd9: code = SSD_9;
      default: code = SSD_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ssd_refresh_tick.sv
// Free-running prescaler: pcnt counts 0..DIV-1 and tick marks the terminal count.
module ssd_refresh_tick #(
  parameter int DIV = 100000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [$clog2(DIV)-1:0] pcnt,
  output logic                   tick
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  assign tick = (pcnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + 1'b1;
  end

endmodule

// File: rtl/ssd_scan_ctl.sv
// Self-timed common-anode seven-segment scanner with frame-synchronous double buffering,
// dead time between digits, and per-digit blank/blink.
module ssd_scan_ctl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SEG_W        = SSD_BIT_WIDTH,
  parameter int REFRESH_DIV  = 100000,
  parameter int DEAD_CYCLES  = 1000,
  parameter int BLINK_FRAMES = 100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SEG_W*NUM_DIGITS-1:0] in_ssd,
  input  logic                        load,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  output logic                        load_pending,
  output logic                        frame_done,
  output logic [NUM_DIGITS-1:0]       an,
  output logic [SEG_W-1:0]            ssd
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int PCNT_W = $clog2(REFRESH_DIV);
  localparam int BCNT_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PCNT_W-1:0] DEAD_END  = PCNT_W'(DEAD_CYCLES);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);

  logic [PCNT_W-1:0]           pcnt_p0;
  logic                        tick_p0;
  logic                        wrap_p0;
  logic                        dark_p0;
  logic [IDX_W-1:0]            idx;
  logic [SEG_W*NUM_DIGITS-1:0] pending;
  logic [SEG_W*NUM_DIGITS-1:0] shadow;
  logic [BCNT_W-1:0]           blink_cnt;
  logic                        blink_phase;
  logic [NUM_DIGITS-1:0]       an_p1;
  logic [SEG_W-1:0]            ssd_p1;

  ssd_refresh_tick #(.DIV(REFRESH_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .pcnt  (pcnt_p0),
    .tick  (tick_p0)
  );

  assign wrap_p0 = tick_p0 && (idx == IDX_LAST);
  assign dark_p0 = (pcnt_p0 < DEAD_END) || blank_mask[idx] || (blink_phase && blink_mask[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       idx <= '0;
    else if (tick_p0) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
  end

  // Shadow only changes at a wrap, so a frame is never shown half old, half new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '1;
      shadow       <= '1;
      load_pending <= 1'b0;
    end else begin
      if (wrap_p0 && load_pending) shadow <= pending;
      if (load) begin
        pending      <= in_ssd;
        load_pending <= 1'b1;
      end else if (wrap_p0) begin
        load_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= wrap_p0;
      if (wrap_p0) begin
        if (blink_cnt == BCNT_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // p0 -> p1: registered pin drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p1  <= '1;
      ssd_p1 <= '1;
    end else if (dark_p0) begin
      an_p1  <= '1;
      ssd_p1 <= '1;
    end else begin
      an_p1  <= ~(NUM_DIGITS'(1) << idx);
      ssd_p1 <= shadow[SEG_W*idx +: SEG_W];
    end
  end

  assign an  = an_p1;
  assign ssd = ssd_p1;

endmodule

// File: tb/tb_ssd_scan_ctl.sv
// Bench for ssd_scan_ctl: cycle model feeds an expectation queue, plus directed scenario checks.
module tb_ssd_scan_ctl;
  import ssd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_ssd;
  logic        load;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic        load_pending;
  logic        frame_done;
  logic [3:0]  an;
  logic [7:0]  ssd;

  int total = 0;
  int bad   = 0;

  ssd_scan_ctl #(
    .NUM_DIGITS   (4),
    .SEG_W        (8),
    .REFRESH_DIV  (4),
    .DEAD_CYCLES  (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_ssd       (in_ssd),
    .load         (load),
    .blank_mask   (blank_mask),
    .blink_mask   (blink_mask),
    .load_pending (load_pending),
    .frame_done   (frame_done),
    .an           (an),
    .ssd          (ssd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef struct {
    logic [3:0] an;
    logic [7:0] ssd;
    logic       fd;
    logic       lp;
  } exp_t;

  exp_t        q[$];
  int          m_pcnt, m_idx, m_bcnt;
  bit          m_phase, m_lp, m_tick, m_wrap, m_dark;
  logic [31:0] m_pend, m_shad;
  exp_t        m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pcnt = 0; m_idx = 0; m_bcnt = 0; m_phase = 0; m_lp = 0;
      m_pend = 32'hFFFF_FFFF; m_shad = 32'hFFFF_FFFF;
      q.delete();
    end else begin
      m_tick = (m_pcnt == 3);
      m_wrap = m_tick && (m_idx == 3);
      m_dark = (m_pcnt == 0) || blank_mask[m_idx] || (m_phase && blink_mask[m_idx]);
      case (m_idx)
        0: m_e.an = 4'b1110;
        1: m_e.an = 4'b1101;
        2: m_e.an = 4'b1011;
        default: m_e.an = 4'b0111;
      endcase
      m_e.ssd = m_shad[8*m_idx +: 8];
      if (m_dark) begin
        m_e.an  = 4'hF;
        m_e.ssd = 8'hFF;
      end
      m_e.fd = m_wrap;
      if (m_wrap && m_lp) m_shad = m_pend;
      if (load) begin
        m_pend = in_ssd;
        m_lp   = 1;
      end else if (m_wrap) begin
        m_lp = 0;
      end
      m_e.lp = m_lp;
      if (m_wrap) begin
        if (m_bcnt == 1) begin m_bcnt = 0; m_phase = !m_phase; end
        else m_bcnt = m_bcnt + 1;
      end
      if (m_tick) begin
        m_pcnt = 0;
        m_idx  = (m_idx == 3) ? 0 : m_idx + 1;
      end else begin
        m_pcnt = m_pcnt + 1;
      end
      q.push_back(m_e);
    end
  end

  // Scoreboard pop plus whole-run invariants
  exp_t got_e;
  logic fd_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_an", an, 4'hF);
      chk("rst_ssd", ssd, 8'hFF);
      chk("rst_lp", load_pending, 1'b0);
      chk("rst_fd", frame_done, 1'b0);
    end else if (q.size() > 0) begin
      got_e = q.pop_front();
      chk("sb_an", an, got_e.an);
      chk("sb_ssd", ssd, got_e.ssd);
      chk("sb_fd", frame_done, got_e.fd);
      chk("sb_lp", load_pending, got_e.lp);
    end
    chk("an_onehot", 32'($countones(~an) <= 1), 1);
    if (an == 4'hF) chk("dark_ssd", ssd, 8'hFF);
    chk("fd_double", 32'(fd_prev && frame_done), 0);
    fd_prev = frame_done;
  end

  task automatic wait_model(input int want_idx, input int want_pcnt, input string tag);
    int n = 0;
    while (!(m_idx == want_idx && m_pcnt == want_pcnt) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 100);
    if (n >= 100) chk("fd_timeout", 0, 1);
  endtask

  task automatic pulse_load(input logic [31:0] data);
    in_ssd = data;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_c1_an"}, an, 4'hF);
    @(posedge clk); #1;
    chk({tag, "_c2_an"}, an, 4'hE);
  endtask

  logic [31:0] data_a, data_b;
  bit          lit [6];
  int          n_gap, cnt_1101;

  initial begin
    rst_n = 1'b0; load = 1'b0; in_ssd = '0; blank_mask = '0; blink_mask = '0;
    repeat (3) @(negedge clk);
    release_reset("rel0");

    // Scan order and frame period
    pulse_load({SSD_3, SSD_2, SSD_1, SSD_0});
    wait_fd(n_gap);
    wait_fd(n_gap);
    chk("fd_period", n_gap, 16);
    repeat (16) @(negedge clk);

    // Tearing: load mid-frame, visible only from next frame
    wait_model(2, 1, "t3");
    pulse_load({SSD_7, SSD_6, SSD_5, SSD_4});
    chk("t3_lp_set", load_pending, 1'b1);
    wait_fd(n_gap);
    chk("t3_lp_clr", load_pending, 1'b0);
    repeat (16) @(negedge clk);

    // Load/wrap collision
    data_a = {ssd_digit(4'd9), ssd_digit(4'd8), ssd_digit(4'd7), ssd_digit(4'd6)};
    data_b = {ssd_digit(4'd1), ssd_digit(4'd2), ssd_digit(4'd3), ssd_digit(4'd4)};
    wait_model(0, 1, "t4a");
    pulse_load(data_a);
    wait_model(3, 3, "t4b");
    pulse_load(data_b);
    chk("t4_lp_hold", load_pending, 1'b1);
    wait_fd(n_gap);
    wait_fd(n_gap);
    chk("t4_lp_clr", load_pending, 1'b0);

    // Blank digit 1
    blank_mask = 4'b0010;
    cnt_1101 = 0;
    repeat (32) begin
      @(negedge clk);
      if (an == 4'b1101) cnt_1101++;
    end
    chk("t5_blank", cnt_1101, 0);
    blank_mask = 4'b0000;

    // Mid-scan reset with a pending load, then blink from a fresh frame count
    wait_model(2, 2, "t1");
    pulse_load({SSD_0, SSD_0, SSD_0, SSD_0});
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t1_async_an", an, 4'hF);
    chk("t1_async_ssd", ssd, 8'hFF);
    chk("t1_async_lp", load_pending, 1'b0);
    blink_mask = 4'b0001;
    release_reset("rel1");
    for (int f = 0; f < 6; f++) lit[f] = 1'b0;
    for (int j = 2; j < 96; j++) begin
      @(negedge clk);
      if (an == 4'hE) lit[j / 16] = 1'b1;
    end
    lit[0] = 1'b1;
    for (int f = 0; f < 6; f++)
      chk($sformatf("t5_blink_f%0d", f), lit[f], ((f / 2) % 2) == 0);
    blink_mask = 4'b0000;

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
